// File: rtl/color_sample_scheduler_pkg.sv
// Shared types and constants for the colour sample scheduler: FSM states,
// default CLS381 register addresses, error-counter ceiling and a channel helper.
package color_sched_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_R    = 3'd1,
    RD_G    = 3'd2,
    RD_B    = 3'd3,
    ACCUM   = 3'd4,
    PUBLISH = 3'd5
  } sched_state_t;

  localparam logic [7:0] DEF_REG_R   = 8'h10;
  localparam logic [7:0] DEF_REG_G   = 8'h0D;
  localparam logic [7:0] DEF_REG_B   = 8'h13;
  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

  function automatic logic [7:0] abs_diff8(input logic [7:0] a, input logic [7:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/color_sample_scheduler_if.sv
// Single-outstanding register-read handshake between the scheduler (master)
// and the I2C read engine (slave).
interface color_sched_i2c_if;
  logic       i2c_req;
  logic [7:0] i2c_reg;
  logic       i2c_done;
  logic       i2c_err;
  logic [7:0] i2c_rdata;

  modport master (output i2c_req, output i2c_reg,
                  input  i2c_done, input i2c_err, input i2c_rdata);
  modport slave  (input  i2c_req, input i2c_reg,
                  output i2c_done, output i2c_err, output i2c_rdata);
endinterface

// File: rtl/color_sample_scheduler_period_tick_gen.sv
// Enable-gated period counter: one registered tick every PERIOD cycles while
// enable is high; dropping enable restarts the period from zero.
module period_tick_gen #(
  parameter int unsigned PERIOD = 2_500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);
  localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CW-1:0] cnt;

  // Period counter with wrap-around tick generation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (!enable) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CW'(PERIOD - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + CW'(1);
      tick <= 1'b0;
    end
  end
endmodule

// File: rtl/color_sample_scheduler.sv
// Colour sample scheduler: reads R/G/B from the sensor, averages 2^AVG_LOG2
// rounds and publishes an RGB triple. Optional macro COLOR_SCHED_CHANGE_ONLY_EN
// suppresses publishes whose change stays below DEADBAND on every channel.
module color_sample_scheduler
  import color_sched_pkg::*;
#(
  parameter int unsigned SAMPLE_PERIOD = 2_500_000,
  parameter int unsigned AVG_LOG2      = 2,
  parameter int unsigned TIMEOUT       = 100_000,
  parameter logic [7:0]  REG_R         = DEF_REG_R,
  parameter logic [7:0]  REG_G         = DEF_REG_G,
  parameter logic [7:0]  REG_B         = DEF_REG_B,
  parameter logic [7:0]  DEADBAND      = 8'd4
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              enable,
  input  logic              sample_now,
  color_sched_i2c_if.master i2c,
  output logic [7:0]        data_r_out,
  output logic [7:0]        data_g_out,
  output logic [7:0]        data_b_out,
  output logic              rgb_valid,
  output logic              busy,
  output logic [7:0]        err_cnt
);
`ifdef COLOR_SCHED_CHANGE_ONLY_EN
  localparam bit CHANGE_ONLY = 1'b1;
`else
  localparam bit CHANGE_ONLY = 1'b0;
`endif

  localparam int unsigned SW     = 8 + AVG_LOG2;
  localparam int unsigned RW     = AVG_LOG2 + 1;
  localparam int unsigned TW     = $clog2(TIMEOUT) + 1;
  localparam int unsigned ROUNDS = 1 << AVG_LOG2;

  sched_state_t   state;
  logic           tick;
  logic           pending;
  logic           published;
  logic [TW-1:0]  wait_cnt;
  logic [RW-1:0]  round_cnt;
  logic [7:0]     hold_r, hold_g, hold_b;
  logic [SW-1:0]  sum_r, sum_g, sum_b;
  logic [SW-1:0]  sum_r_nx, sum_g_nx, sum_b_nx;
  logic [7:0]     avg_r, avg_g, avg_b;
  logic           fire;
  logic           timeout_hit;

  period_tick_gen #(.PERIOD(SAMPLE_PERIOD)) u_tick (
    .clk    (sys_clk),
    .rst_n  (sys_rst_n),
    .enable (enable),
    .tick   (tick)
  );

  assign timeout_hit = (wait_cnt == TW'(TIMEOUT - 1));

  // Sums including the round being accumulated, their average, and the publish gate.
  always_comb begin
    sum_r_nx = sum_r + SW'(hold_r);
    sum_g_nx = sum_g + SW'(hold_g);
    sum_b_nx = sum_b + SW'(hold_b);
    avg_r    = 8'(sum_r_nx >> AVG_LOG2);
    avg_g    = 8'(sum_g_nx >> AVG_LOG2);
    avg_b    = 8'(sum_b_nx >> AVG_LOG2);
    fire     = 1'b1;
    if (CHANGE_ONLY && published) begin
      fire = (abs_diff8(avg_r, data_r_out) >= DEADBAND) ||
             (abs_diff8(avg_g, data_g_out) >= DEADBAND) ||
             (abs_diff8(avg_b, data_b_out) >= DEADBAND);
    end else begin
      fire = 1'b1;
    end
  end

  // Sequencer FSM with registered handshake and publish outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      pending     <= 1'b0;
      published   <= 1'b0;
      wait_cnt    <= '0;
      round_cnt   <= '0;
      hold_r      <= 8'd0;
      hold_g      <= 8'd0;
      hold_b      <= 8'd0;
      sum_r       <= '0;
      sum_g       <= '0;
      sum_b       <= '0;
      i2c.i2c_req <= 1'b0;
      i2c.i2c_reg <= 8'd0;
      data_r_out  <= 8'd0;
      data_g_out  <= 8'd0;
      data_b_out  <= 8'd0;
      rgb_valid   <= 1'b0;
      busy        <= 1'b0;
      err_cnt     <= 8'd0;
    end else begin
      rgb_valid <= 1'b0;
      if (tick || sample_now) begin
        pending <= 1'b1;
      end
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (pending) begin
            pending     <= 1'b0;
            state       <= RD_R;
            i2c.i2c_req <= 1'b1;
            i2c.i2c_reg <= REG_R;
            busy        <= 1'b1;
          end
        end
        RD_R, RD_G, RD_B: begin
          // A NACK beats a same-cycle done; a done beats the timeout.
          if (i2c.i2c_err || (!i2c.i2c_done && timeout_hit)) begin
            err_cnt     <= (err_cnt == ERR_CNT_MAX) ? err_cnt : err_cnt + 8'd1;
            sum_r       <= '0;
            sum_g       <= '0;
            sum_b       <= '0;
            round_cnt   <= '0;
            wait_cnt    <= '0;
            i2c.i2c_req <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end else if (i2c.i2c_done) begin
            wait_cnt <= '0;
            case (state)
              RD_R: begin
                hold_r      <= i2c.i2c_rdata;
                i2c.i2c_reg <= REG_G;
                state       <= RD_G;
              end
              RD_G: begin
                hold_g      <= i2c.i2c_rdata;
                i2c.i2c_reg <= REG_B;
                state       <= RD_B;
              end
              default: begin
                hold_b      <= i2c.i2c_rdata;
                i2c.i2c_req <= 1'b0;
                state       <= ACCUM;
              end
            endcase
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        ACCUM: begin
          sum_r     <= sum_r_nx;
          sum_g     <= sum_g_nx;
          sum_b     <= sum_b_nx;
          round_cnt <= round_cnt + RW'(1);
          // Outputs update here so rgb_valid is high during the PUBLISH cycle.
          if (round_cnt == RW'(ROUNDS - 1)) begin
            state <= PUBLISH;
            if (fire) begin
              data_r_out <= avg_r;
              data_g_out <= avg_g;
              data_b_out <= avg_b;
              rgb_valid  <= 1'b1;
              published  <= 1'b1;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        PUBLISH: begin
          sum_r     <= '0;
          sum_g     <= '0;
          sum_b     <= '0;
          round_cnt <= '0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          i2c.i2c_req <= 1'b0;
          busy        <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/color_sample_scheduler.md
Name: color_sample_scheduler

Overview:
Sequencer between the CLS381 I2C read engine and the WS2812 colour path. On a periodic tick or an on-demand request it issues three register reads (R, G, B) through a single-outstanding req/done handshake. It averages 2^AVG_LOG2 rounds and publishes the resulting 8-bit RGB triple, with a valid pulse, to the LED driver. It owns timeout/NACK recovery so the LED path never stalls on a hung bus.

Parameters:
SAMPLE_PERIOD, 2_500_000, sys_clk cycles between automatic sample rounds (50 ms at 50 MHz)
AVG_LOG2, 2, log2 of rounds averaged per publish (0..4)
TIMEOUT, 100_000, max cycles waiting for i2c_done/i2c_err per read
REG_R, 8'h10, sensor register address for red
REG_G, 8'h0D, sensor register address for green
REG_B, 8'h13, sensor register address for blue
DEADBAND, 8'd4, minimum channel change for a publish (CHANGE_ONLY_EN only)

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  asynchronous active-low reset
enable  in  1  level; 1 = periodic sampling active
sample_now  in  1  single-cycle pulse; request one round immediately
i2c_req  out  1  read request, held high until done/err/timeout
i2c_reg  out  8  register address, stable while i2c_req high
i2c_done  in  1  single-cycle pulse; i2c_rdata valid this cycle
i2c_err  in  1  single-cycle pulse; NACK/arbitration failure
i2c_rdata  in  8  read data
data_r_out  out  8  published red
data_g_out  out  8  published green
data_b_out  out  8  published blue
rgb_valid  out  1  single-cycle pulse on every publish
busy  out  1  high in any state other than IDLE
err_cnt  out  8  saturating count of failed reads

Behaviour:
- Reset: all outputs 0, state IDLE, accumulators 0, round counter 0, period timer 0, pending flag 0.
- Period timer: counts while enable=1; at SAMPLE_PERIOD-1 it emits tick and wraps to 0. enable=0 clears timer to 0.
- Pending flag: set by tick or sample_now; cleared on IDLE->RD_R. Any number of triggers while busy collapse into one pending round.
- States: IDLE, RD_R, RD_G, RD_B, ACCUM, PUBLISH.
- IDLE: on pending=1 -> RD_R. sample_now is honoured even with enable=0.
- RD_x: i2c_req=1 and i2c_reg=REG_x from the first cycle in state. On i2c_done, latch i2c_rdata into the channel holding register and advance R->G->B->ACCUM. i2c_req drops the cycle after done.
- Error or timeout in RD_x:
  - Triggers: i2c_err, or the wait counter reaching TIMEOUT-1 (i2c_err wins over simultaneous i2c_done).
  - Action: err_cnt increments (saturates at 255), the current round is discarded, accumulators and round counter clear, no publish, -> IDLE.
- ACCUM (1 cycle): sum_x += hold_x, with sums of width 8+AVG_LOG2. Round counter increments. If the counter equals 2^AVG_LOG2-1 before increment -> PUBLISH; else -> IDLE and wait for the next trigger.
- PUBLISH (1 cycle): data_x_out = sum_x >> AVG_LOG2 (truncate). rgb_valid=1. Sums and counter clear. -> IDLE.
- Latency: rgb_valid asserts exactly 2 cycles after the final i2c_done of the last round.
- Outputs hold their last published value indefinitely, including across errors.
- enable falling mid-round: the current round completes normally. Only new ticks stop.
- AVG_LOG2=0: every round publishes, and outputs equal the raw readings.

Optional Feature:
- Macro: COLOR_SCHED_CHANGE_ONLY_EN.
- When defined: PUBLISH updates the outputs and pulses rgb_valid only if some channel satisfies |new - current out| >= DEADBAND. Otherwise outputs and rgb_valid stay unchanged, but sums still clear. The first publish after reset always fires.
- When undefined: every PUBLISH updates the outputs and pulses rgb_valid, and DEADBAND is unused.

Decomposition:
- Package color_sched_pkg holds:
  - the state enum (IDLE, RD_R, RD_G, RD_B, ACCUM, PUBLISH);
  - the default register-address constants;
  - the err_cnt saturation constant.
- One natural sub-module, period_tick_gen: the enable-gated SAMPLE_PERIOD counter producing tick.
- The FSM, accumulators and timeout counter live in the top module.

Test Plan:
- AVG_LOG2=0, sample_now, model returns R=0x40, G=0x80, B=0xC0 -> i2c_reg sequence 0x10, 0x0D, 0x13; outputs 40/80/C0; rgb_valid 2 cycles after the third done.
- AVG_LOG2=2, enable=1, SAMPLE_PERIOD=100, R readings 10, 20, 30, 41 -> one rgb_valid after round 4 with data_r_out=25; no pulse on rounds 1-3.
- i2c_err on the G read -> err_cnt=1, no rgb_valid, outputs unchanged; the next round, if complete, publishes normally.
- Model never answers, TIMEOUT=50 -> i2c_req drops after 50 cycles, err_cnt increments, FSM returns to IDLE.
- Three sample_now pulses during one busy round -> exactly one extra round follows.
- COLOR_SCHED_CHANGE_ONLY_EN, DEADBAND=4, outputs 80/80/80, new average 82/79/83 -> no rgb_valid; 80/80/85 -> rgb_valid with outputs updated.
